// File: rtl/ppu_pkg.sv
// Shared types and constants for the PPU memory writer: write targets, memory
// geometry, the queued write entry and the host header field positions.
package ppu_pkg;

   typedef enum logic [2:0] {
      TGT_TILE_BUFFER     = 3'd0,
      TGT_TILE_GRAPHICS   = 3'd1,
      TGT_SPRITE_GRAPHICS = 3'd2,
      TGT_COLOR_PALETTES  = 3'd3,
      TGT_OAM             = 3'd4
   } target_e;

   typedef enum logic {
      ST_HDR,
      ST_PAYLOAD
   } parser_state_e;

   localparam int AW_TILE_BUFFER     = 9;
   localparam int AW_TILE_GRAPHICS   = 11;
   localparam int AW_SPRITE_GRAPHICS = 11;
   localparam int AW_COLOR_PALETTES  = 3;
   localparam int AW_OAM             = 8;

   localparam int DEPTH_TILE_BUFFER     = 1 << AW_TILE_BUFFER;
   localparam int DEPTH_TILE_GRAPHICS   = 1 << AW_TILE_GRAPHICS;
   localparam int DEPTH_SPRITE_GRAPHICS = 1 << AW_SPRITE_GRAPHICS;
   localparam int DEPTH_COLOR_PALETTES  = 1 << AW_COLOR_PALETTES;
   localparam int DEPTH_OAM             = 1 << AW_OAM;

   localparam int HDR_TGT_MSB  = 31;
   localparam int HDR_TGT_LSB  = 29;
   localparam int HDR_CNT_MSB  = 26;
   localparam int HDR_CNT_LSB  = 16;
   localparam int HDR_ADDR_MSB = 10;
   localparam int HDR_ADDR_LSB = 0;

   typedef struct packed {
      logic [2:0]  target;
      logic [10:0] addr;
      logic [31:0] data;
   } fifo_entry_t;

   function automatic logic target_valid(input logic [2:0] t);
      return t <= 3'd4;
   endfunction

   // Invalid targets get an all-zero mask so their address never moves.
   function automatic logic [10:0] addr_mask(input logic [2:0] t);
      case (t)
         TGT_TILE_BUFFER:     return 11'h1FF;
         TGT_TILE_GRAPHICS:   return 11'h7FF;
         TGT_SPRITE_GRAPHICS: return 11'h7FF;
         TGT_COLOR_PALETTES:  return 11'h007;
         TGT_OAM:             return 11'h0FF;
         default:             return 11'h000;
      endcase
   endfunction

endpackage

// File: rtl/ppu_mem_writer_if.sv
// Push/pop channel between the command parser and the write FIFO.
// push/pop are single-cycle requests; a push is taken when full=0, a pop when empty=0.
interface ppu_mem_writer_if;
   import ppu_pkg::*;

   logic        push;
   logic        pop;
   logic        full;
   logic        empty;
   fifo_entry_t wr_entry;
   fifo_entry_t rd_entry;

   modport master (output push, pop, wr_entry, input full, empty, rd_entry);
   modport slave  (input push, pop, wr_entry, output full, empty, rd_entry);
endinterface

// File: rtl/ppu_wr_fifo.sv
// Synchronous show-ahead FIFO of pending memory writes; rd_entry always shows the head.
module ppu_wr_fifo
   import ppu_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic               clk,
   input  logic               reset,
   ppu_mem_writer_if.slave    wr_if
);
   localparam int PW = $clog2(DEPTH);

   fifo_entry_t   mem_q [DEPTH];
   logic [PW:0]   wr_ptr_q, rd_ptr_q;
   logic          do_push, do_pop;

   // Extra pointer MSB distinguishes full from empty when the low bits match.
   assign wr_if.empty = (wr_ptr_q == rd_ptr_q);
   assign wr_if.full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                        (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign do_push     = wr_if.push & ~wr_if.full;
   assign do_pop      = wr_if.pop  & ~wr_if.empty;
   assign wr_if.rd_entry = mem_q[rd_ptr_q[PW-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + {{PW{1'b0}}, 1'b1};
         if (do_pop)  rd_ptr_q <= rd_ptr_q + {{PW{1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= wr_if.wr_entry;
   end
endmodule

// File: rtl/ppu_mem_writer.sv
// Host command parser feeding a write FIFO that drains into the PPU memories
// during vertical blanking, one registered write per cycle.
module ppu_mem_writer
   import ppu_pkg::*;
#(
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] write_data,
   input  logic        write,
   input  logic        chipselect,
   output logic        waitrequest,
   input  logic        vblank,
   output logic        rw_tile_buffer,
   output logic        rw_tile_graphics,
   output logic        rw_sprite_graphics,
   output logic        rw_color_palettes,
   output logic        rw_OAM,
   output logic [8:0]  addr_tile_buffer,
   output logic [10:0] addr_tile_graphics,
   output logic [10:0] addr_sprite_graphics,
   output logic [2:0]  addr_color_palettes,
   output logic [7:0]  addr_OAM,
   output logic [31:0] write_data_tile_buffer,
   output logic [31:0] write_data_tile_graphics,
   output logic [31:0] write_data_sprite_graphics,
   output logic [31:0] write_data_OAM,
   output logic [23:0] write_data_color_palettes,
   output logic        cmd_error
);
   parser_state_e state_q, state_d;
   logic [2:0]    tgt_q, tgt_d;
   logic [10:0]   remaining_q, remaining_d;
   logic [10:0]   cur_addr_q, cur_addr_d;
   logic          cmd_error_q, cmd_error_d;
   logic          stall, accept;
   logic [2:0]    hdr_tgt;
   logic [10:0]   hdr_cnt, hdr_addr;

   ppu_mem_writer_if wr_if ();

   ppu_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .wr_if (wr_if.slave)
   );

   assign hdr_tgt  = write_data[HDR_TGT_MSB:HDR_TGT_LSB];
   assign hdr_cnt  = write_data[HDR_CNT_MSB:HDR_CNT_LSB];
   assign hdr_addr = write_data[HDR_ADDR_MSB:HDR_ADDR_LSB];

   // Only payload words bound for a real memory can be held off by a full FIFO.
   assign stall       = (state_q == ST_PAYLOAD) && target_valid(tgt_q) && wr_if.full;
   assign waitrequest = stall;
   assign accept      = write & chipselect & ~stall;
   assign cmd_error   = cmd_error_q;

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_HDR;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_HDR:     if (accept && hdr_cnt != 11'd0)      state_d = ST_PAYLOAD;
         ST_PAYLOAD: if (accept && remaining_q == 11'd1)  state_d = ST_HDR;
         default:                                          state_d = ST_HDR;
      endcase
   end

   always_comb begin
      wr_if.push     = (state_q == ST_PAYLOAD) && accept && target_valid(tgt_q);
      wr_if.wr_entry = '{target: tgt_q, addr: cur_addr_q, data: write_data};
   end

   always_comb begin
      tgt_d       = tgt_q;
      remaining_d = remaining_q;
      cur_addr_d  = cur_addr_q;
      cmd_error_d = cmd_error_q;
      if (accept) begin
         if (state_q == ST_HDR) begin
            if (hdr_cnt != 11'd0) begin
               tgt_d       = hdr_tgt;
               remaining_d = hdr_cnt;
               cur_addr_d  = hdr_addr & addr_mask(hdr_tgt);
               if (!target_valid(hdr_tgt)) cmd_error_d = 1'b1;
            end
         end else begin
            remaining_d = remaining_q - 11'd1;
            cur_addr_d  = (cur_addr_q + 11'd1) & addr_mask(tgt_q);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tgt_q       <= '0;
         remaining_q <= '0;
         cur_addr_q  <= '0;
         cmd_error_q <= 1'b0;
      end else begin
         tgt_q       <= tgt_d;
         remaining_q <= remaining_d;
         cur_addr_q  <= cur_addr_d;
         cmd_error_q <= cmd_error_d;
      end
   end

   // Drain side: pop gated by the live vblank, so a falling vblank stops pops at once.
   assign wr_if.pop = vblank & ~wr_if.empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         rw_tile_buffer             <= 1'b0;
         rw_tile_graphics           <= 1'b0;
         rw_sprite_graphics         <= 1'b0;
         rw_color_palettes          <= 1'b0;
         rw_OAM                     <= 1'b0;
         addr_tile_buffer           <= '0;
         addr_tile_graphics         <= '0;
         addr_sprite_graphics       <= '0;
         addr_color_palettes        <= '0;
         addr_OAM                   <= '0;
         write_data_tile_buffer     <= '0;
         write_data_tile_graphics   <= '0;
         write_data_sprite_graphics <= '0;
         write_data_OAM             <= '0;
         write_data_color_palettes  <= '0;
      end else begin
         rw_tile_buffer     <= 1'b0;
         rw_tile_graphics   <= 1'b0;
         rw_sprite_graphics <= 1'b0;
         rw_color_palettes  <= 1'b0;
         rw_OAM             <= 1'b0;
         if (wr_if.pop) begin
            case (wr_if.rd_entry.target)
               TGT_TILE_BUFFER: begin
                  rw_tile_buffer         <= 1'b1;
                  addr_tile_buffer       <= wr_if.rd_entry.addr[8:0];
                  write_data_tile_buffer <= wr_if.rd_entry.data;
               end
               TGT_TILE_GRAPHICS: begin
                  rw_tile_graphics         <= 1'b1;
                  addr_tile_graphics       <= wr_if.rd_entry.addr;
                  write_data_tile_graphics <= wr_if.rd_entry.data;
               end
               TGT_SPRITE_GRAPHICS: begin
                  rw_sprite_graphics         <= 1'b1;
                  addr_sprite_graphics       <= wr_if.rd_entry.addr;
                  write_data_sprite_graphics <= wr_if.rd_entry.data;
               end
               TGT_COLOR_PALETTES: begin
                  rw_color_palettes         <= 1'b1;
                  addr_color_palettes       <= wr_if.rd_entry.addr[2:0];
                  write_data_color_palettes <= wr_if.rd_entry.data[23:0];
               end
               TGT_OAM: begin
                  rw_OAM         <= 1'b1;
                  addr_OAM       <= wr_if.rd_entry.addr[7:0];
                  write_data_OAM <= wr_if.rd_entry.data;
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_ppu_mem_writer.sv
// Scoreboard bench for ppu_mem_writer: commands are modelled as a list of
// expected memory writes which a monitor matches against every rw pulse.
module tb_ppu_mem_writer;
   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] write_data;
   logic        write, chipselect, waitrequest, vblank;
   logic        rw_tile_buffer, rw_tile_graphics, rw_sprite_graphics, rw_color_palettes, rw_OAM;
   logic [8:0]  addr_tile_buffer;
   logic [10:0] addr_tile_graphics, addr_sprite_graphics;
   logic [2:0]  addr_color_palettes;
   logic [7:0]  addr_OAM;
   logic [31:0] write_data_tile_buffer, write_data_tile_graphics, write_data_sprite_graphics, write_data_OAM;
   logic [23:0] write_data_color_palettes;
   logic        cmd_error;

   always #5 clk = ~clk;

   ppu_mem_writer #(.FIFO_DEPTH(16)) dut (
      .clk(clk), .reset(reset), .write_data(write_data), .write(write),
      .chipselect(chipselect), .waitrequest(waitrequest), .vblank(vblank),
      .rw_tile_buffer(rw_tile_buffer), .rw_tile_graphics(rw_tile_graphics),
      .rw_sprite_graphics(rw_sprite_graphics), .rw_color_palettes(rw_color_palettes),
      .rw_OAM(rw_OAM), .addr_tile_buffer(addr_tile_buffer),
      .addr_tile_graphics(addr_tile_graphics), .addr_sprite_graphics(addr_sprite_graphics),
      .addr_color_palettes(addr_color_palettes), .addr_OAM(addr_OAM),
      .write_data_tile_buffer(write_data_tile_buffer),
      .write_data_tile_graphics(write_data_tile_graphics),
      .write_data_sprite_graphics(write_data_sprite_graphics),
      .write_data_OAM(write_data_OAM),
      .write_data_color_palettes(write_data_color_palettes),
      .cmd_error(cmd_error)
   );

   // Expected write: {target[2:0], addr[10:0], data[31:0]}
   logic [45:0] exp_q[$];
   logic [31:0] pl_q[$];
   int          checks = 0;
   int          errors = 0;
   int          n_writes = 0;
   bit          rand_vb_en = 1'b0;
   logic        vb_last = 1'b0;
   logic [40:0] prev_tb;
   logic [42:0] prev_tg, prev_sg;
   logic [26:0] prev_pal;
   logic [39:0] prev_oam;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic int depth_of(input int t);
      case (t)
         0: return 512;
         1: return 2048;
         2: return 2048;
         3: return 8;
         default: return 256;
      endcase
   endfunction

   // Monitor: every rw pulse must match the oldest outstanding expected write.
   always @(negedge clk) begin : monitor
      int          nrw;
      logic [45:0] act;
      logic [45:0] e;
      nrw = int'(rw_tile_buffer) + int'(rw_tile_graphics) + int'(rw_sprite_graphics)
          + int'(rw_color_palettes) + int'(rw_OAM);
      if (!reset) begin
         if (nrw != 0) begin
            check("rw_one_hot", 64'(nrw), 64'd1);
            check("rw_needs_vblank", 64'(vb_last), 64'd1);
            act = '0;
            if (rw_tile_buffer)          act = {3'd0, 2'd0, addr_tile_buffer, write_data_tile_buffer};
            else if (rw_tile_graphics)   act = {3'd1, addr_tile_graphics, write_data_tile_graphics};
            else if (rw_sprite_graphics) act = {3'd2, addr_sprite_graphics, write_data_sprite_graphics};
            else if (rw_color_palettes)  act = {3'd3, 8'd0, addr_color_palettes, 8'd0, write_data_color_palettes};
            else                         act = {3'd4, 3'd0, addr_OAM, write_data_OAM};
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL write_unexpected actual=%0h required=no_write", act);
            end else begin
               e = exp_q.pop_front();
               check("write_entry", 64'(act), 64'(e));
            end
            n_writes++;
         end
         if (!rw_tile_buffer)     check("hold_tile_buffer", 64'({addr_tile_buffer, write_data_tile_buffer}), 64'(prev_tb));
         if (!rw_tile_graphics)   check("hold_tile_graphics", 64'({addr_tile_graphics, write_data_tile_graphics}), 64'(prev_tg));
         if (!rw_sprite_graphics) check("hold_sprite_graphics", 64'({addr_sprite_graphics, write_data_sprite_graphics}), 64'(prev_sg));
         if (!rw_color_palettes)  check("hold_palettes", 64'({addr_color_palettes, write_data_color_palettes}), 64'(prev_pal));
         if (!rw_OAM)             check("hold_oam", 64'({addr_OAM, write_data_OAM}), 64'(prev_oam));
      end
      prev_tb  = {addr_tile_buffer, write_data_tile_buffer};
      prev_tg  = {addr_tile_graphics, write_data_tile_graphics};
      prev_sg  = {addr_sprite_graphics, write_data_sprite_graphics};
      prev_pal = {addr_color_palettes, write_data_color_palettes};
      prev_oam = {addr_OAM, write_data_OAM};
      vb_last  = vblank;
   end

   always begin
      @(posedge clk);
      #1;
      if (rand_vb_en) vblank = ($urandom_range(0, 3) != 0);
   end

   // Drives one word until the DUT takes it; returns one step after the accepting edge.
   task automatic write_word(input logic [31:0] d, output bit ok);
      int n;
      n = 0;
      ok = 1'b0;
      write_data = d;
      write = 1'b1;
      chipselect = 1'b1;
      while (!ok && n < 400) begin
         @(negedge clk);
         if (!waitrequest) ok = 1'b1;
         else n++;
         @(posedge clk);
         #1;
      end
      write = 1'b0;
      chipselect = 1'b0;
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout actual=stalled required=accepted word=%0h", d);
      end
   endtask

   task automatic idle_junk();
      int k;
      k = $urandom_range(0, 2);
      repeat (k) begin
         write_data = $urandom;
         if ($urandom_range(0, 1) == 0) begin write = 1'b1; chipselect = 1'b0; end
         else begin write = 1'b0; chipselect = 1'b1; end
         @(posedge clk);
         #1;
      end
      write = 1'b0;
      chipselect = 1'b0;
   endtask

   // Header plus cnt payload words from pl_q; the model appends the writes it implies.
   task automatic send_cmd(input int tgt, input int cnt, input int addr);
      bit          ok;
      logic [31:0] d;
      int          a;
      write_word({3'(tgt), 2'b00, 11'(cnt), 5'b0, 11'(addr)}, ok);
      for (int i = 0; i < cnt; i++) begin
         idle_junk();
         d = pl_q[i];
         write_word(d, ok);
         if (ok && tgt < 5) begin
            a = (addr + i) % depth_of(tgt);
            if (tgt == 3) d = {8'd0, d[23:0]};
            exp_q.push_back({3'(tgt), 11'(a), d});
         end
      end
   endtask

   task automatic fill_payload(input int n);
      pl_q.delete();
      for (int i = 0; i < n; i++) pl_q.push_back($urandom);
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 600) begin
         @(posedge clk);
         n++;
      end
      check(name, 64'(exp_q.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_state(input string name);
      check({name, "_ctrl"}, 64'({rw_tile_buffer, rw_tile_graphics, rw_sprite_graphics,
                                  rw_color_palettes, rw_OAM, waitrequest, cmd_error}), 64'd0);
      check({name, "_addr"}, 64'({addr_tile_buffer, addr_tile_graphics, addr_sprite_graphics,
                                  addr_color_palettes, addr_OAM}), 64'd0);
      check({name, "_data"}, 64'(|{write_data_tile_buffer, write_data_tile_graphics,
                                   write_data_sprite_graphics, write_data_OAM,
                                   write_data_color_palettes}), 64'd0);
   endtask

   initial begin : main
      bit ok;
      int w0;
      reset = 1'b1; vblank = 1'b0; write = 1'b0; chipselect = 1'b0; write_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_state("reset");
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Minimum latency with an empty FIFO and vblank high.
      vblank = 1'b1;
      write_word(32'h0001_0020, ok);
      write_word(32'h1234_5678, ok);
      exp_q.push_back({3'd0, 11'h20, 32'h1234_5678});
      @(negedge clk);
      check("latency_cycle1_idle", 64'(rw_tile_buffer), 64'd0);
      @(negedge clk);
      check("latency_cycle2_write", 64'(rw_tile_buffer), 64'd1);
      wait_drain("drain_latency");

      pl_q = '{32'hA, 32'hB, 32'hC};
      send_cmd(0, 3, 5);
      wait_drain("drain_tile_buffer");

      pl_q = '{32'h00FF_0000, 32'h0000_FF00};
      send_cmd(3, 2, 7);
      wait_drain("drain_palette_wrap");

      // Back-pressure: 16 entries fill the FIFO with vblank low.
      vblank = 1'b0;
      w0 = n_writes;
      fill_payload(20);
      write_word({3'd4, 2'b00, 11'd20, 5'b0, 11'd0}, ok);
      for (int i = 0; i < 16; i++) begin
         write_word(pl_q[i], ok);
         if (ok) exp_q.push_back({3'd4, 11'(i), pl_q[i]});
      end
      write_data = pl_q[16]; write = 1'b1; chipselect = 1'b1;
      repeat (3) @(negedge clk);
      check("stall_when_full", 64'(waitrequest), 64'd1);
      check("no_write_without_vblank", 64'(n_writes - w0), 64'd0);
      @(posedge clk);
      #1;
      vblank = 1'b1;
      for (int i = 16; i < 20; i++) begin
         write_word(pl_q[i], ok);
         if (ok) exp_q.push_back({3'd4, 11'(i), pl_q[i]});
      end
      wait_drain("drain_oam_full");

      // vblank drops after exactly five pops.
      vblank = 1'b0;
      fill_payload(10);
      send_cmd(2, 10, 100);
      w0 = n_writes;
      vblank = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      vblank = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("partial_drain_count", 64'(n_writes - w0), 64'd5);
      vblank = 1'b1;
      wait_drain("drain_resume");
      check("resume_count", 64'(n_writes - w0), 64'd10);

      rand_vb_en = 1'b1;
      for (int c = 0; c < 25; c++) begin
         fill_payload(8);
         send_cmd($urandom_range(0, 4), $urandom_range(0, 6), $urandom_range(0, 2047));
         idle_junk();
      end
      rand_vb_en = 1'b0;
      @(posedge clk);
      #1;
      vblank = 1'b1;
      wait_drain("drain_random");
      check("cmd_error_clear", 64'(cmd_error), 64'd0);

      // Bad target with a full FIFO: words are discarded without stalling.
      vblank = 1'b0;
      fill_payload(16);
      send_cmd(0, 16, 300);
      w0 = n_writes;
      write_word({3'd6, 2'b00, 11'd3, 5'b0, 11'd4}, ok);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("discard_no_stall", 64'(waitrequest), 64'd0);
         @(posedge clk);
         #1;
         write_word($urandom, ok);
      end
      @(negedge clk);
      check("cmd_error_set", 64'(cmd_error), 64'd1);
      @(posedge clk);
      #1;
      vblank = 1'b1;
      wait_drain("drain_after_discard");
      check("discard_write_count", 64'(n_writes - w0), 64'd16);
      check("cmd_error_sticky", 64'(cmd_error), 64'd1);

      // Reset mid-payload and mid-drain.
      vblank = 1'b0;
      fill_payload(5);
      write_word({3'd1, 2'b00, 11'd5, 5'b0, 11'd0}, ok);
      write_word(pl_q[0], ok);
      write_word(pl_q[1], ok);
      vblank = 1'b1;
      reset = 1'b1;
      exp_q.delete();
      @(posedge clk);
      @(negedge clk);
      check_reset_state("mid_reset");
      @(posedge clk);
      #1;
      reset = 1'b0;
      pl_q = '{32'hCAFE_F00D};
      send_cmd(0, 1, 9);
      wait_drain("drain_after_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog actual=running required=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ppu_mem_writer.md
PPU_MEM_WRITER -- requirements
Module: ppu_mem_writer

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, named as in the PPU.
REQ-002 Parameter FIFO_DEPTH, default 16, SHALL set the number of pending write entries; it SHALL be a power of two, 4..64.
REQ-003 The port list SHALL be as follows, clock and reset first:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- write_data  in  32  host bus write word.
- write  in  1  host write strobe.
- chipselect  in  1  host select.
- waitrequest  out  1  host stall.
- vblank  in  1  VGA vertical blanking.
- rw_tile_buffer, rw_tile_graphics, rw_sprite_graphics, rw_color_palettes, rw_OAM  out  1 each  memory write enables, 1 = write.
- addr_tile_buffer  out  9.
- addr_tile_graphics, addr_sprite_graphics  out  11.
- addr_color_palettes  out  3.
- addr_OAM  out  8.
- write_data_tile_buffer, write_data_tile_graphics, write_data_sprite_graphics, write_data_OAM  out  32.
- write_data_color_palettes  out  24.
- cmd_error  out  1  sticky flag for a bad target.

Function
REQ-004 A host word SHALL be accepted on a cycle with write=1, chipselect=1 and waitrequest=0.
REQ-005 The command parser SHALL have two states, HDR and PAYLOAD, and SHALL reset into HDR.
REQ-006 In HDR, an accepted word SHALL be decoded as a header with these fields:
- target = [31:29]: 0 tile_buffer, 1 tile_graphics, 2 sprite_graphics, 3 color_palettes, 4 OAM.
- count = [26:16].
- start address = [10:0].
REQ-007 A header with count=0 SHALL be a no-op, and the parser SHALL stay in HDR.
REQ-008 A header with count>0 SHALL load remaining=count and cur_addr=start, then go to PAYLOAD.
REQ-009 In PAYLOAD, each accepted word SHALL be pushed to the FIFO as {target, cur_addr, data}; cur_addr SHALL then increment and remaining SHALL decrement.
REQ-010 The parser SHALL return to HDR after the payload word that brings remaining to 0.
REQ-011 cur_addr SHALL be masked to the target memory width (9, 11, 11, 3 or 8 bits); incrementing past the top address SHALL wrap to 0.
REQ-012 For targets 5..7, the count payload words SHALL be accepted and discarded, and cmd_error SHALL be set to 1 and stay 1 until reset.
REQ-013 waitrequest SHALL be 1 only when the FIFO is full and the parser is in PAYLOAD with a valid target; headers and discarded words SHALL never stall.
REQ-014 Memory writes SHALL be issued only while vblank=1, at a rate of one FIFO entry per cycle.
REQ-015 Each pop SHALL register exactly one rw_<target> high for one cycle, together with its addr_ and write_data_ values.
REQ-016 On a pop to color_palettes, the palette data SHALL be bits [23:0].
REQ-017 The latency from accept to the rw pulse SHALL be at least 2 cycles, and exactly 2 when vblank=1 and the FIFO is empty.
REQ-018 When vblank falls, no new pop SHALL occur in the following cycle; an output already registered SHALL complete, and no entry SHALL be lost or reordered.
REQ-019 A push and a pop in the same cycle SHALL both take effect and leave the occupancy unchanged.
REQ-020 The addr_ and write_data_ outputs SHALL hold their last values whenever rw is 0.

Reset
REQ-021 On reset, all rw_ outputs, addr_ outputs, write_data_ outputs, waitrequest and cmd_error SHALL be 0.
REQ-022 On reset, the FIFO SHALL be empty, the parser SHALL be in HDR, and remaining and cur_addr SHALL be 0.
REQ-023 Reset asserted mid-payload or mid-drain SHALL abandon all pending entries, and no rw pulse SHALL occur in the cycle after reset.

Structure
REQ-024 Package ppu_pkg SHALL hold:
- the target enum;
- the memory depth and address width constants;
- the FIFO entry struct {target[2:0], addr[10:0], data[31:0]};
- the header field bit positions.
REQ-025 The FIFO SHALL be the single sub-module ppu_wr_fifo: synchronous, with show-ahead data, full/empty flags, and width taken from the entry struct.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Header 0x0003_0005 then payload 0xA, 0xB, 0xC with vblank=1 -> rw_tile_buffer pulses at addr 5, 6, 7 with data 0xA, 0xB, 0xC.
- Header target 3, count 2, addr 7, payload 0x00FF0000, 0x0000FF00 -> palette writes at addr 7 then 0 (wrap), data 0xFF0000 then 0x00FF00.
- vblank=0, header target 4, count 20, addr 0 -> waitrequest rises after 16 payload words with no rw activity; raising vblank drains 0..15, then the last 4 entries are accepted and written at 16..19 in order.
- Header target 6, count 3 -> 3 words absorbed, no rw pulse, waitrequest stays 0, cmd_error=1 until reset.
- vblank falls after 5 of 10 entries drain -> exactly 5 writes; the remaining 5 are written in order at the next vblank.
- Reset asserted mid-payload -> all outputs 0, FIFO empty; the next word is parsed as a header.
